wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the scalar and vector register-file write ports between two sources:
//  - In-order pipeline writeback (Pipe): cannot be reordered, can be stalled.
//  - Long-latency return path (Q): e.g. deferred loads or vector ops, valid/ready, buffered in an internal FIFO.
//  Sits between the writeback stage and decode's register files. Drives registered write-port signals.
//  A starvation counter guarantees the queued path forward progress.
// PARAMETERS
//  REG_WIDTH     16  scalar data width
//  VREG_WIDTH    64  vector data width
//  IDX_WIDTH     6   register index width
//  FIFO_DEPTH    4   Q buffer entries; power of two, >=2
//  STARVE_LIMIT  3   conflicts Q head may lose before it wins; 0 = Q always wins
// PORTS
//  I_CLOCK             in   1           clock
//  I_RESET_N           in   1           async active-low reset
//  I_LOCK              in   1           0 = no grants (pipeline frozen)
//  I_PipeValid         in   1           pipe has a writeback this cycle
//  I_PipeIsVec         in   1           1 = vector port target, 0 = scalar
//  I_PipeRegIdx        in   IDX_WIDTH   destination register
//  I_PipeData          in   REG_WIDTH   scalar data
//  I_PipeVData         in   VREG_WIDTH  vector data
//  O_PipeStall         out  1           comb; pipe request not taken, hold stable
//  I_QValid            in   1           Q push request
//  I_QIsVec            in   1           as I_PipeIsVec
//  I_QRegIdx           in   IDX_WIDTH   destination register
//  I_QData             in   REG_WIDTH   scalar data
//  I_QVData            in   VREG_WIDTH  vector data
//  O_QReady            out  1           FIFO not full
//  O_QCount            out  clog2(D)+1  FIFO occupancy
//  O_WriteBackEnable   out  1           scalar write enable
//  O_WriteBackRegIdx   out  IDX_WIDTH   scalar write index
//  O_WriteBackData     out  REG_WIDTH   scalar write data
//  O_VWriteBackEnable  out  1           vector write enable
//  O_VWriteBackRegIdx  out  IDX_WIDTH   vector write index
//  O_VWriteBackData    out  VREG_WIDTH  vector write data
// BEHAVIOUR
//  Reset (async, I_RESET_N=0):
//   - All write-port outputs 0; O_PipeStall=0; O_QReady=0; O_QCount=0.
//   - FIFO emptied, starve_cnt=0. Reset mid-operation discards queued entries.
//  Q push: when I_QValid && O_QReady. O_QReady = !full, from registered state only.
//   - No bypass: an entry pushed into an empty FIFO is head next cycle.
//   - Minimum push-to-port latency is 2 cycles.
//   - Full: no push. A pop and push in the same cycle is legal when not full.
//  Grant (comb, each cycle, I_LOCK=1):
//   - Each port (scalar, vector) is given to at most one source.
//   - conflict = PipeValid && head valid && PipeIsVec==head.IsVec.
//   - No conflict: every valid requester is granted. Pipe and head may use different ports in the same cycle.
//   - Conflict: head wins iff starve_cnt==STARVE_LIMIT; otherwise Pipe wins.
//   - O_PipeStall = I_PipeValid && !pipe_grant.
//  I_LOCK=0:
//   - No grants, no pops. O_PipeStall=0; pipe is frozen by the system.
//   - Pushes still accepted. Write enables 0 next cycle.
//  starve_cnt:
//   - Cleared on head pop.
//   - +1 (saturating at STARVE_LIMIT) on a lost conflict.
//   - Unchanged otherwise.
//  Output register: the granted request drives the port's enable/idx/data on the next edge.
//   - Unused port: enable=0, idx=0, data=0.
//  Ordering between Pipe and Q writes to the same register is not enforced here; the decode scoreboard owns it.
// STRUCTURE
//  - Shared header: IDX_WIDTH, port-select encoding (PORT_S=0, PORT_V=1), request struct field widths.
//  - Sub-module wb_req_fifo: ptrs with wrap bit, full/empty/count, head outputs.
//  - Arbitration and starve counter live in the top module.
// TESTING
//  - Pipe scalar r5=0x1234, Q empty -> next cycle WB_En=1, idx 5, data 0x1234; stall 0.
//  - Pipe scalar r3 + Q head vector v2=0xA5..A5 -> both ports enabled next cycle; QCount 1->0.
//  - STARVE_LIMIT=3, Pipe scalar every cycle, Q head scalar r7:
//    - Pipe wins 3 cycles; 4th cycle O_PipeStall=1 and r7 written.
//    - Next cycle Pipe held request is written.
//  - I_LOCK=0, push 4 -> QCount 4, O_QReady 0, 5th push dropped; I_LOCK=1 -> drains in order, one per cycle.
//  - 3 queued, I_RESET_N low mid-cycle -> outputs 0 immediately, QCount 0; after release, no stale writes.
//  - Push into empty FIFO at cycle t -> port write visible at t+2, not t+1.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter: port encoding and default widths.
package wb_port_arbiter_pkg;

    // Which register-file write port a request targets
    typedef enum logic {
        PORT_S = 1'b0,
        PORT_V = 1'b1
    } portSel_e;

    localparam int DEF_REG_WIDTH  = 16;
    localparam int DEF_VREG_WIDTH = 64;
    localparam int DEF_IDX_WIDTH  = 6;

    // Width of one queued request: {isVec, regIdx, data, vData}
    function automatic int reqWidth(input int idxW, input int regW, input int vregW);
        return 1 + idxW + regW + vregW;
    endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Request buffer for the long-latency return path; wrap-bit pointers, no bypass.
module wb_req_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             headValid,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    assign count     = wrPtr - rdPtr;
    assign full      = (count == (AW+1)'(DEPTH));
    assign headValid = (count != '0);
    assign doPush    = push && !full;
    assign doPop     = pop && headValid;
    assign headData  = mem[rdPtr[AW-1:0]];

    // Pointer update; the wrap bit disambiguates full from empty
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read
    always_ff @(posedge gclk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the scalar and vector write ports between the in-order pipe and the queued return path.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int REG_WIDTH    = DEF_REG_WIDTH,
    parameter int VREG_WIDTH   = DEF_VREG_WIDTH,
    parameter int IDX_WIDTH    = DEF_IDX_WIDTH,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  I_CLOCK,
    input  logic                  I_RESET_N,
    input  logic                  I_LOCK,
    input  logic                  I_PipeValid,
    input  logic                  I_PipeIsVec,
    input  logic [IDX_WIDTH-1:0]  I_PipeRegIdx,
    input  logic [REG_WIDTH-1:0]  I_PipeData,
    input  logic [VREG_WIDTH-1:0] I_PipeVData,
    output logic                  O_PipeStall,
    input  logic                  I_QValid,
    input  logic                  I_QIsVec,
    input  logic [IDX_WIDTH-1:0]  I_QRegIdx,
    input  logic [REG_WIDTH-1:0]  I_QData,
    input  logic [VREG_WIDTH-1:0] I_QVData,
    output logic                  O_QReady,
    output logic [CW-1:0]         O_QCount,
    output logic                  O_WriteBackEnable,
    output logic [IDX_WIDTH-1:0]  O_WriteBackRegIdx,
    output logic [REG_WIDTH-1:0]  O_WriteBackData,
    output logic                  O_VWriteBackEnable,
    output logic [IDX_WIDTH-1:0]  O_VWriteBackRegIdx,
    output logic [VREG_WIDTH-1:0] O_VWriteBackData
);

    localparam int EW = reqWidth(IDX_WIDTH, REG_WIDTH, VREG_WIDTH);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [EW-1:0]         headEntry;
    logic                  headValid;
    logic                  fifoFull;
    portSel_e              headSel;
    portSel_e              pipeSel;
    logic [IDX_WIDTH-1:0]  headIdx;
    logic [REG_WIDTH-1:0]  headData;
    logic [VREG_WIDTH-1:0] headVData;
    logic                  conflict;
    logic                  headWins;
    logic                  pipeGrant;
    logic                  qGrant;
    logic [SW-1:0]         starveCnt;

    // Reset gating keeps ready low while held in reset
    assign O_QReady = I_RESET_N && !fifoFull;

    wb_req_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) uFifo (
        .gclk      (I_CLOCK),
        .grst_n    (I_RESET_N),
        .push      (I_QValid && O_QReady),
        .pushData  ({I_QIsVec, I_QRegIdx, I_QData, I_QVData}),
        .pop       (qGrant),
        .headData  (headEntry),
        .headValid (headValid),
        .full      (fifoFull),
        .count     (O_QCount)
    );

    assign headSel   = portSel_e'(headEntry[EW-1]);
    assign headIdx   = headEntry[EW-2 -: IDX_WIDTH];
    assign headData  = headEntry[VREG_WIDTH +: REG_WIDTH];
    assign headVData = headEntry[VREG_WIDTH-1:0];
    assign pipeSel   = portSel_e'(I_PipeIsVec);

    // Per-cycle grant: the queue head only beats the pipe once it has lost LIMIT conflicts
    always_comb begin
        conflict  = I_PipeValid && headValid && (pipeSel == headSel);
        headWins  = conflict && (starveCnt == LIMIT);
        pipeGrant = I_LOCK && I_PipeValid && !headWins;
        qGrant    = I_LOCK && headValid && (!conflict || headWins);
    end

    // A frozen pipe (lock low) is not stalled by us
    assign O_PipeStall = I_LOCK && I_PipeValid && !pipeGrant;

    // Starvation counter: reset on every head pop, saturating count of lost conflicts
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N)
            starveCnt <= '0;
        else if (qGrant)
            starveCnt <= '0;
        else if (I_LOCK && conflict && !headWins && starveCnt != LIMIT)
            starveCnt <= starveCnt + 1'b1;
    end

    // Registered write ports; an idle port drives all zeros
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            O_WriteBackEnable  <= 1'b0;
            O_WriteBackRegIdx  <= '0;
            O_WriteBackData    <= '0;
            O_VWriteBackEnable <= 1'b0;
            O_VWriteBackRegIdx <= '0;
            O_VWriteBackData   <= '0;
        end else begin
            O_WriteBackEnable  <= 1'b0;
            O_WriteBackRegIdx  <= '0;
            O_WriteBackData    <= '0;
            O_VWriteBackEnable <= 1'b0;
            O_VWriteBackRegIdx <= '0;
            O_VWriteBackData   <= '0;
            if (pipeGrant && pipeSel == PORT_S) begin
                O_WriteBackEnable <= 1'b1;
                O_WriteBackRegIdx <= I_PipeRegIdx;
                O_WriteBackData   <= I_PipeData;
            end else if (qGrant && headSel == PORT_S) begin
                O_WriteBackEnable <= 1'b1;
                O_WriteBackRegIdx <= headIdx;
                O_WriteBackData   <= headData;
            end
            if (pipeGrant && pipeSel == PORT_V) begin
                O_VWriteBackEnable <= 1'b1;
                O_VWriteBackRegIdx <= I_PipeRegIdx;
                O_VWriteBackData   <= I_PipeVData;
            end else if (qGrant && headSel == PORT_V) begin
                O_VWriteBackEnable <= 1'b1;
                O_VWriteBackRegIdx <= headIdx;
                O_VWriteBackData   <= headVData;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: stimulus queues expected port writes, a negedge monitor retires them.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rstN;
    logic        lock;
    logic        pipeValid, pipeIsVec;
    logic [5:0]  pipeIdx;
    logic [15:0] pipeData;
    logic [63:0] pipeVData;
    logic        pipeStall;
    logic        qValid, qIsVec;
    logic [5:0]  qIdx;
    logic [15:0] qData;
    logic [63:0] qVData;
    logic        qReady;
    logic [2:0]  qCount;
    logic        wbEn, vwbEn;
    logic [5:0]  wbIdx, vwbIdx;
    logic [15:0] wbData;
    logic [63:0] vwbData;

    int checks = 0;
    int errors = 0;
    logic [79:0] sq[$];
    logic [79:0] vq[$];

    wb_port_arbiter #(
        .REG_WIDTH(16), .VREG_WIDTH(64), .IDX_WIDTH(6), .FIFO_DEPTH(4), .STARVE_LIMIT(3)
    ) dut (
        .I_CLOCK(clk), .I_RESET_N(rstN), .I_LOCK(lock),
        .I_PipeValid(pipeValid), .I_PipeIsVec(pipeIsVec), .I_PipeRegIdx(pipeIdx),
        .I_PipeData(pipeData), .I_PipeVData(pipeVData), .O_PipeStall(pipeStall),
        .I_QValid(qValid), .I_QIsVec(qIsVec), .I_QRegIdx(qIdx), .I_QData(qData),
        .I_QVData(qVData), .O_QReady(qReady), .O_QCount(qCount),
        .O_WriteBackEnable(wbEn), .O_WriteBackRegIdx(wbIdx), .O_WriteBackData(wbData),
        .O_VWriteBackEnable(vwbEn), .O_VWriteBackRegIdx(vwbIdx), .O_VWriteBackData(vwbData)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every enabled port write must match the oldest expected write for that port
    always @(negedge clk) begin
        if (rstN) begin
            if (wbEn) begin
                if (sq.size() == 0) check("wb_s_unexpected", {1'b1, wbIdx, wbData}, 80'h0);
                else check("wb_s", {wbIdx, wbData}, sq.pop_front());
            end
            if (vwbEn) begin
                if (vq.size() == 0) check("wb_v_unexpected", {1'b1, vwbIdx, vwbData}, 80'h0);
                else check("wb_v", {vwbIdx, vwbData}, vq.pop_front());
            end
        end
    end

    initial begin
        rstN = 1'b0; lock = 1'b1;
        pipeValid = 0; pipeIsVec = 0; pipeIdx = '0; pipeData = '0; pipeVData = '0;
        qValid = 0; qIsVec = 0; qIdx = '0; qData = '0; qVData = '0;

        // Reset state
        #3;
        check("rst_wben", wbEn, 0);
        check("rst_vwben", vwbEn, 0);
        check("rst_stall", pipeStall, 0);
        check("rst_qready", qReady, 0);
        check("rst_qcount", qCount, 0);
        tick(); tick();
        rstN = 1'b1;
        #1;
        check("post_rst_qready", qReady, 1);

        // Pipe scalar r5 with an empty queue
        pipeValid = 1; pipeIsVec = 0; pipeIdx = 6'd5; pipeData = 16'h1234;
        #1;
        check("t1_stall", pipeStall, 0);
        sq.push_back({6'd5, 16'h1234});
        tick();
        pipeValid = 0;

        // Queue vector v2 and pipe scalar r3 share the cycle on different ports
        qValid = 1; qIsVec = 1; qIdx = 6'd2; qData = 16'hBEEF; qVData = 64'hA5A5_A5A5_A5A5_A5A5;
        tick();
        qValid = 0;
        check("t2_qcount1", qCount, 1);
        pipeValid = 1; pipeIsVec = 0; pipeIdx = 6'd3; pipeData = 16'h3333;
        #1;
        check("t2_stall", pipeStall, 0);
        sq.push_back({6'd3, 16'h3333});
        vq.push_back({6'd2, 64'hA5A5_A5A5_A5A5_A5A5});
        tick();
        pipeValid = 0;
        check("t2_qcount0", qCount, 0);

        // Push into empty FIFO: nothing at t+1, written at t+2
        qValid = 1; qIsVec = 0; qIdx = 6'd9; qData = 16'h0999;
        tick();
        qValid = 0;
        check("lat_t1_en", wbEn, 0);
        sq.push_back({6'd9, 16'h0999});
        tick();
        check("lat_t2_en", wbEn, 1);

        // Starvation: Q head scalar r7 loses three conflicts, wins the fourth
        qValid = 1; qIsVec = 0; qIdx = 6'd7; qData = 16'h0777;
        tick();
        qValid = 0;
        for (int i = 0; i < 4; i++) begin
            pipeValid = 1; pipeIsVec = 0; pipeIdx = 6'd1; pipeData = 16'h0101 + 16'(i);
            #1;
            check($sformatf("starve_stall%0d", i), pipeStall, (i == 3));
            if (i == 3) sq.push_back({6'd7, 16'h0777});
            else        sq.push_back({6'd1, 16'h0101 + 16'(i)});
            tick();
        end
        #1;
        check("starve_held_stall", pipeStall, 0);
        sq.push_back({6'd1, 16'h0104});
        tick();
        pipeValid = 0;
        check("starve_qcount", qCount, 0);

        // Lock low: pushes accepted up to full, no grants, no stall
        lock = 0;
        for (int i = 0; i < 4; i++) begin
            qValid = 1; qIsVec = 1; qIdx = 6'd10 + 6'(i); qData = 16'hBEEF;
            qVData = 64'h0123_4567_89AB_CD00 + 64'(i);
            tick();
        end
        check("lock_qcount4", qCount, 4);
        check("lock_qready0", qReady, 0);
        qIdx = 6'd14; qVData = 64'hDEAD;
        tick();
        qValid = 0;
        check("lock_5th_dropped", qCount, 4);
        pipeValid = 1; pipeIsVec = 1; pipeIdx = 6'd40;
        #1;
        check("lock_stall", pipeStall, 0);
        pipeValid = 0;
        for (int i = 0; i < 4; i++) vq.push_back({6'd10 + 6'(i), 64'h0123_4567_89AB_CD00 + 64'(i)});
        lock = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("drain_qcount%0d", i), qCount, 3'(3 - i));
        end
        tick();

        // Reset mid-operation with three queued and one write on the port
        lock = 0;
        for (int i = 0; i < 3; i++) begin
            qValid = 1; qIsVec = 0; qIdx = 6'd20 + 6'(i); qData = 16'h2000 + 16'(i);
            tick();
        end
        qValid = 0;
        check("rst3_qcount", qCount, 3);
        lock = 1;
        pipeValid = 1; pipeIsVec = 0; pipeIdx = 6'd30; pipeData = 16'h3030;
        tick();
        pipeValid = 0; lock = 0;
        check("rst_pre_en", wbEn, 1);
        #1 rstN = 1'b0;
        #1;
        check("rst_mid_en", wbEn, 0);
        check("rst_mid_data", wbData, 0);
        check("rst_mid_qcount", qCount, 0);
        check("rst_mid_qready", qReady, 0);
        tick(); tick();
        rstN = 1'b1; lock = 1;
        for (int i = 0; i < 4; i++) tick();
        check("post_rst2_qcount", qCount, 0);
        check("post_rst2_qready", qReady, 1);
        tick();

        check("sq_drained", 80'(sq.size()), 0);
        check("vq_drained", 80'(vq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
